mb_crush_ctrl: RTL

//  Sample-rate sequencer and configuration controller for the bitcrush effect stage in the PCM effect chain.

---
 rtl/mb_crush_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mb_crush_ctrl.sv
// mb_crush_ctrl: bit-depth masking and sample-and-hold decimation for the bitcrush stage.
// Depth moves one bit per RAMP_SAMPLES accepted samples so enable/retarget never clicks.
module mb_crush_ctrl #(
    parameter int DATA_W        = 16,
    parameter int RAMP_SAMPLES  = 64,
    parameter int DEFAULT_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        sample_valid,
    input  logic [DATA_W-1:0]           pcm_in,
    input  logic                        cfg_load,
    input  logic [$clog2(DATA_W+1)-1:0] depth_req,
    input  logic [3:0]                  decim_req,
    output logic [DATA_W-1:0]           pcm_out,
    output logic                        pcm_valid,
    output logic [$clog2(DATA_W+1)-1:0] cur_depth,
    output logic                        ramping
);

    localparam int DW   = $clog2(DATA_W + 1);
    localparam int RC_W = (RAMP_SAMPLES > 1) ? $clog2(RAMP_SAMPLES) : 1;

    localparam logic [DW-1:0]   FULL     = DW'(DATA_W);
    localparam logic [DW-1:0]   DEF_TGT  = DW'(DEFAULT_DEPTH);
    localparam logic [RC_W-1:0] RAMP_END = RC_W'(RAMP_SAMPLES - 1);

    typedef enum logic [1:0] {
        BYPASS,
        RAMP_DN,
        CRUSH,
        RAMP_UP
    } state_t;

    state_t            state;
    logic [DW-1:0]     target;
    logic [DW-1:0]     eff_tgt;
    logic [DW-1:0]     clamp_req;
    logic [3:0]        decim;
    logic [3:0]        hold_cnt;
    logic [DATA_W-1:0] held;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] src;
    logic [RC_W-1:0]   ramp_cnt;
    logic              capture;
    logic              step;

    always_comb begin
        clamp_req = depth_req;
        if (depth_req == '0) begin
            clamp_req = DW'(1);
        end else if (depth_req > FULL) begin
            clamp_req = FULL;
        end
    end

    // Disabling the effect is just a ramp toward full depth.
    assign eff_tgt = enable ? target : FULL;

    assign mask    = {DATA_W{1'b1}} << (FULL - cur_depth);
    assign capture = (state == BYPASS) || (hold_cnt == '0);
    assign src     = capture ? pcm_in : held;
    assign step    = sample_valid && (ramp_cnt == RAMP_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
            held      <= '0;
            hold_cnt  <= '0;
            decim     <= '0;
            target    <= DEF_TGT;
        end else begin
            pcm_valid <= sample_valid;
            if (sample_valid) begin
                pcm_out <= src & mask;
                if (state == BYPASS) begin
                    held     <= pcm_in;
                    hold_cnt <= '0;
                end else if (hold_cnt == '0) begin
                    held     <= pcm_in;
                    hold_cnt <= decim;
                end else begin
                    hold_cnt <= hold_cnt - 4'd1;
                end
            end
            // decim is only consumed at a hold boundary, so mid-hold loads wait.
            if (cfg_load) begin
                target <= clamp_req;
                decim  <= decim_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BYPASS;
            cur_depth <= FULL;
            ramp_cnt  <= '0;
            ramping   <= 1'b0;
        end else begin
            unique case (state)
                BYPASS: begin
                    if (enable) begin
                        ramp_cnt <= '0;
                        if (target < FULL) begin
                            state   <= RAMP_DN;
                            ramping <= 1'b1;
                        end else begin
                            state <= CRUSH;
                        end
                    end
                end
                RAMP_DN: begin
                    if (eff_tgt > cur_depth) begin
                        state    <= RAMP_UP;
                        ramp_cnt <= '0;
                    end else if (eff_tgt == cur_depth) begin
                        state   <= CRUSH;
                        ramping <= 1'b0;
                    end else if (sample_valid) begin
                        if (step) begin
                            ramp_cnt  <= '0;
                            cur_depth <= cur_depth - DW'(1);
                        end else begin
                            ramp_cnt <= ramp_cnt + RC_W'(1);
                        end
                    end
                end
                RAMP_UP: begin
                    if (eff_tgt < cur_depth) begin
                        state    <= RAMP_DN;
                        ramp_cnt <= '0;
                    end else if (eff_tgt == cur_depth) begin
                        state   <= enable ? CRUSH : BYPASS;
                        ramping <= 1'b0;
                    end else if (sample_valid) begin
                        if (step) begin
                            ramp_cnt  <= '0;
                            cur_depth <= cur_depth + DW'(1);
                        end else begin
                            ramp_cnt <= ramp_cnt + RC_W'(1);
                        end
                    end
                end
                CRUSH: begin
                    if (eff_tgt < cur_depth) begin
                        state    <= RAMP_DN;
                        ramp_cnt <= '0;
                        ramping  <= 1'b1;
                    end else if (eff_tgt > cur_depth) begin
                        state    <= RAMP_UP;
                        ramp_cnt <= '0;
                        ramping  <= 1'b1;
                    end else if (!enable) begin
                        // Already at full depth: nothing to ramp, drop straight out.
                        state <= BYPASS;
                    end
                end
                default: begin
                    state   <= BYPASS;
                    ramping <= 1'b0;
                end
            endcase
        end
    end

endmodule
